// File: rtl/snake_tile_renderer.sv
// Snake tile renderer: scan pixel -> tile class -> sprite colour; fixed 3-cycle latency, no backpressure (free-running scan).
// Double-buffered body table; `define SELF_HIT_DETECT_EN adds the registered self_hit output.
module snake_tile_renderer #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int X_OFF             = 58,
    parameter int Y_OFF             = 43,
    parameter int BLOCK_SIZE        = 5,
    parameter int GRID_W            = 124,
    parameter int GRID_H            = 81,
    parameter int COORD_BIT         = 7,
    parameter int SNAKE_LENGTH_BIT  = 4,
    parameter int SNAKE_LENGTH_MAX  = 16
) (
    input  logic                         clock_25,
    input  logic                         reset,
    input  logic [PIXEL_DISPLAY_BIT:0]   X,
    input  logic [PIXEL_DISPLAY_BIT:0]   Y,
    input  logic [COORD_BIT-1:0]         snake_head_x,
    input  logic [COORD_BIT-1:0]         snake_head_y,
    input  logic [COORD_BIT-1:0]         fruit_x,
    input  logic [COORD_BIT-1:0]         fruit_y,
    input  logic [SNAKE_LENGTH_BIT-1:0]  snake_length,
    input  logic                         body_wr_en,
    input  logic [SNAKE_LENGTH_BIT-1:0]  body_wr_idx,
    input  logic [COORD_BIT-1:0]         body_wr_x,
    input  logic [COORD_BIT-1:0]         body_wr_y,
    input  logic                         frame_commit,
    output logic                         swap_pending,
    output logic [1:0]                   sprite_figure,
    output logic [2:0]                   sprite_px_x,
    output logic [2:0]                   sprite_px_y,
    input  logic [1:0]                   sprite_data,
    output logic                         game_area,
    output logic                         game_enable,
    output logic [1:0]                   game_data
`ifdef SELF_HIT_DETECT_EN
    ,
    output logic                         self_hit
`endif
);
    localparam int PW = PIXEL_DISPLAY_BIT + 1;
    localparam int IW = (SNAKE_LENGTH_MAX > 1) ? $clog2(SNAKE_LENGTH_MAX) : 1;
    localparam logic [PW-1:0] X_LO = PW'(X_OFF);
    localparam logic [PW-1:0] X_HI = PW'(X_OFF + GRID_W * BLOCK_SIZE - 1);
    localparam logic [PW-1:0] Y_LO = PW'(Y_OFF);
    localparam logic [PW-1:0] Y_HI = PW'(Y_OFF + GRID_H * BLOCK_SIZE - 1);
    localparam logic [2:0]    L_LAST = 3'(BLOCK_SIZE - 1);
    localparam logic [COORD_BIT-1:0] T_ONE = COORD_BIT'(1);

    logic [2:0]           s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d, row_l_q, row_l_d;
    logic [COORD_BIT-1:0] s1_tx_q, s1_tx_d, s1_ty_q, s1_ty_d, row_t_q, row_t_d;
    logic                 s1_in_q, s1_in_d;
    logic [1:0]           fig_q, fig_d;
    logic [2:0]           px_q, px_d, py_q, py_d;
    logic                 s2_hit_q, s2_hit_d, s2_area_q, s2_area_d;
    logic                 area_q, area_d, en_q, en_d;
    logic [1:0]           dat_q, dat_d;
    logic                 pend_q, pend_d, front_q, front_d;
    logic [COORD_BIT-1:0] bank_x_q [2][SNAKE_LENGTH_MAX];
    logic [COORD_BIT-1:0] bank_y_q [2][SNAKE_LENGTH_MAX];

    logic        in_area, at_origin, swap, wr_ok;
    logic        hit_head, hit_body, hit_tail, hit_fruit;
    logic [31:0] wr_idx_ext;
    int          n_eff;

    assign in_area    = (X >= X_LO) && (X <= X_HI) && (Y >= Y_LO) && (Y <= Y_HI);
    assign at_origin  = (X == '0) && (Y == '0);
    assign swap       = at_origin && pend_q;
    assign wr_idx_ext = 32'(body_wr_idx);
    assign wr_ok      = body_wr_en && (wr_idx_ext < 32'(SNAKE_LENGTH_MAX));
    assign n_eff      = (int'(snake_length) > SNAKE_LENGTH_MAX) ? SNAKE_LENGTH_MAX : int'(snake_length);

    // Column state restarts at the left edge; row state restarts above the area
    // and steps once per row on the last area column.
    always_comb begin
        s1_lx_d = s1_lx_q + 3'd1;
        s1_tx_d = s1_tx_q;
        if (X == X_LO) begin
            s1_lx_d = '0;
            s1_tx_d = '0;
        end else if (s1_lx_q == L_LAST) begin
            s1_lx_d = '0;
            s1_tx_d = s1_tx_q + T_ONE;
        end
        row_l_d = row_l_q;
        row_t_d = row_t_q;
        if (Y < Y_LO) begin
            row_l_d = '0;
            row_t_d = '0;
        end else if (X == X_HI) begin
            if (row_l_q == L_LAST) begin
                row_l_d = '0;
                row_t_d = row_t_q + T_ONE;
            end else begin
                row_l_d = row_l_q + 3'd1;
            end
        end
        s1_ly_d = row_l_q;
        s1_ty_d = row_t_q;
        s1_in_d = in_area;
    end

    always_comb begin
        hit_head  = (s1_tx_q == snake_head_x) && (s1_ty_q == snake_head_y);
        hit_fruit = (s1_tx_q == fruit_x) && (s1_ty_q == fruit_y);
        hit_body  = 1'b0;
        hit_tail  = 1'b0;
        for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
            if ((bank_x_q[front_q][i] == s1_tx_q) && (bank_y_q[front_q][i] == s1_ty_q)) begin
                if (i + 3 <= n_eff) hit_body = 1'b1;
                if (i + 2 == n_eff) hit_tail = 1'b1;
            end
        end
        fig_d = 2'b00;
        if (hit_head)       fig_d = 2'b00;
        else if (hit_body)  fig_d = 2'b01;
        else if (hit_tail)  fig_d = 2'b10;
        else if (hit_fruit) fig_d = 2'b11;
        s2_hit_d  = s1_in_q && (hit_head || hit_body || hit_tail || hit_fruit);
        s2_area_d = s1_in_q;
        px_d      = s1_lx_q;
        py_d      = s1_ly_q;
        area_d    = s2_area_q;
        en_d      = s2_hit_q;
        dat_d     = s2_hit_q ? sprite_data : 2'b00;
        // A commit coinciding with the swap is absorbed by that swap.
        pend_d    = swap ? 1'b0 : (frame_commit ? 1'b1 : pend_q);
        front_d   = front_q ^ swap;
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            s1_lx_q <= '0; s1_ly_q <= '0; s1_tx_q <= '0; s1_ty_q <= '0; s1_in_q <= 1'b0;
            row_l_q <= '0; row_t_q <= '0;
            fig_q <= '0; px_q <= '0; py_q <= '0; s2_hit_q <= 1'b0; s2_area_q <= 1'b0;
            area_q <= 1'b0; en_q <= 1'b0; dat_q <= '0;
            pend_q <= 1'b0; front_q <= 1'b0;
        end else begin
            s1_lx_q <= s1_lx_d; s1_ly_q <= s1_ly_d; s1_tx_q <= s1_tx_d; s1_ty_q <= s1_ty_d; s1_in_q <= s1_in_d;
            row_l_q <= row_l_d; row_t_q <= row_t_d;
            fig_q <= fig_d; px_q <= px_d; py_q <= py_d; s2_hit_q <= s2_hit_d; s2_area_q <= s2_area_d;
            area_q <= area_d; en_q <= en_d; dat_q <= dat_d;
            pend_q <= pend_d; front_q <= front_d;
        end
    end

    // Back bank is the one not being displayed before this edge's swap.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
                    bank_x_q[b][i] <= '0;
                    bank_y_q[b][i] <= '0;
                end
            end
        end else if (wr_ok) begin
            bank_x_q[~front_q][wr_idx_ext[IW-1:0]] <= body_wr_x;
            bank_y_q[~front_q][wr_idx_ext[IW-1:0]] <= body_wr_y;
        end
    end

    assign swap_pending  = pend_q;
    assign sprite_figure = fig_q;
    assign sprite_px_x   = px_q;
    assign sprite_px_y   = py_q;
    assign game_area     = area_q;
    assign game_enable   = en_q;
    assign game_data     = dat_q;

`ifdef SELF_HIT_DETECT_EN
    logic self_cmp, acc_q, acc_d, self_hit_q, self_hit_d;

    // Collisions seen anywhere in the frame are published at the frame origin.
    always_comb begin
        self_cmp = 1'b0;
        for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
            if ((i + 2 <= n_eff) && (bank_x_q[front_q][i] == snake_head_x) &&
                (bank_y_q[front_q][i] == snake_head_y))
                self_cmp = 1'b1;
        end
        acc_d      = acc_q | self_cmp;
        self_hit_d = self_hit_q;
        if (at_origin) begin
            self_hit_d = acc_q | self_cmp;
            acc_d      = 1'b0;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            acc_q      <= 1'b0;
            self_hit_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            self_hit_q <= self_hit_d;
        end
    end

    assign self_hit = self_hit_q;
`endif
endmodule

// File: doc/snake_tile_renderer.md
Name: snake_tile_renderer

Overview:
Parametrised successor of the snake game-area renderer. Maps VGA scan coordinates to grid tiles and classifies each tile as head, body, tail, fruit or empty. It fetches the 2-bit pixel colour from an external sprite ROM and drives game_enable/game_data into the VGA colour mux. It adds a double-buffered body table so game logic updates never tear a frame, configurable grid/tile geometry, and a fixed, documented pipeline latency.

Parameters:
PIXEL_DISPLAY_BIT, 9, X/Y counters are PIXEL_DISPLAY_BIT+1 bits
X_OFF, 58, first pixel column of the game area
Y_OFF, 43, first pixel row of the game area
BLOCK_SIZE, 5, tile edge in pixels (2..8)
GRID_W, 124, tiles per row
GRID_H, 81, tiles per column
COORD_BIT, 7, tile coordinate width
SNAKE_LENGTH_BIT, 4, length/index width
SNAKE_LENGTH_MAX, 16, body table depth (head included in length)

Ports:
clock_25  in  1  25 MHz pixel clock
reset  in  1  synchronous, active-high
X, Y  in  PIXEL_DISPLAY_BIT+1  current scan pixel
snake_head_x, snake_head_y  in  COORD_BIT  head tile
fruit_x, fruit_y  in  COORD_BIT  fruit tile
snake_length  in  SNAKE_LENGTH_BIT  segments including head
body_wr_en  in  1  write strobe into back bank
body_wr_idx  in  SNAKE_LENGTH_BIT  segment index (0 = segment behind head)
body_wr_x, body_wr_y  in  COORD_BIT  segment tile
frame_commit  in  1  pulse: back bank complete
swap_pending  out  1  commit latched, swap not yet done
sprite_figure  out  2  HEAD=00 BODY=01 TAIL=10 FRUIT=11
sprite_px_x, sprite_px_y  out  3  pixel within tile
sprite_data  in  2  ROM colour, valid 1 cycle after request
game_area  out  1  registered, scan pixel inside game rectangle
game_enable  out  1  pixel belongs to a figure
game_data  out  2  pixel colour (00 when game_enable=0)

Behaviour:
- One clock; reset is synchronous and active-high. All outputs and internal state clear on a clock edge with reset=1: swap_pending=0, game_area=0, game_enable=0, game_data=00, sprite_figure=00, sprite_px_x/y=0, both banks zeroed, front bank=0.
- Geometry: area spans X_OFF..X_OFF+GRID_W*BLOCK_SIZE-1 and Y_OFF..Y_OFF+GRID_H*BLOCK_SIZE-1. Tile/local counters are computed from X,Y via counters, not dividers: local wraps at BLOCK_SIZE-1, tile column increments on wrap, both reset at area left edge; row counters advance on the last column of the area, reset at Y<Y_OFF.
- Pipeline, fixed latency 3: S1 registers tile/local coordinates and in-area flag; S2 classifies and issues sprite_figure/px; S3 captures sprite_data into game_data, game_enable, game_area. Outputs describe pixel (X,Y) presented 3 cycles earlier; the VGA timing block compensates.
- Classification priority: head > body > tail > fruit. Body entries are indices 0..snake_length-3; tail is index snake_length-2; snake_length<=1 means head only; snake_length>SNAKE_LENGTH_MAX saturates to SNAKE_LENGTH_MAX. Outside the area, game_enable=0.
- Double buffer: writes target the back bank only; classification reads the front bank. frame_commit sets swap_pending; at scan (X=0,Y=0) with swap_pending=1, banks swap and swap_pending clears the same edge. A commit arriving at the swap edge is taken by that swap. Writes at the swap edge land in the old back bank (the new front).
- body_wr_idx >= SNAKE_LENGTH_MAX is ignored.
- Reset mid-frame: pipeline flushes; outputs 0 until 3 valid cycles have elapsed.

Optional Feature:
SELF_HIT_DETECT_EN: adds output self_hit (1 bit, reset 0). Set when any front-bank body/tail entry equals the head tile during a frame; registered and updated at each frame swap point (X=0,Y=0). Without the macro, no port and no comparator logic.

Test Plan:
- Reset held 5 cycles mid-scan -> game_enable=0, game_data=00, swap_pending=0 on all edges.
- Head at (0,0), BLOCK_SIZE=5 -> sprite_figure=00 for X=58..62,Y=43..47; game_enable rises 3 cycles after X=58,Y=43.
- snake_length=4, entries 0=(1,0),1=(2,0),2=(3,0) committed -> tiles 1,2 BODY, tile 3 TAIL; entry 3 is never drawn.
- Head and fruit both at (5,5) -> HEAD drawn, FRUIT suppressed.
- Write back bank mid-frame plus frame_commit -> current frame unchanged; new positions appear from the next frame; swap_pending is 1 until (0,0).
- GRID_W=32, BLOCK_SIZE=8 build -> area right edge at X=58+255; game_area=0 at X=314.
